// File: rtl/barrel_sched.sv
// barrel_sched: round-robin barrel thread scheduler with per-thread PCs.
// It handles redirects and the matching fetch/decode flushes.
module barrel_sched #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 8,
    parameter int RESET_PC      = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                stall_f,
    input  logic [NUM_THREADS-1:0]              thread_en,
    input  logic                                redirect_e,
    input  logic [$clog2(NUM_THREADS)-1:0]      redirect_tid_e,
    input  logic [ADDRESS_WIDTH-1:0]            redirect_pc_e,
    input  logic [$clog2(NUM_THREADS)-1:0]      tid_d,
    input  logic                                valid_d,
    output logic [$clog2(NUM_THREADS)-1:0]      tid_f,
    output logic [ADDRESS_WIDTH-1:0]            pc_f,
    output logic [ADDRESS_WIDTH-1:0]            pc_plus4_f,
    output logic                                valid_f,
    output logic                                flush_f,
    output logic                                flush_d
);
    localparam int BITS_THREADS = $clog2(NUM_THREADS);

    logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
    logic [BITS_THREADS-1:0]  cur_tid, next_tid, idx;
    logic                     cur_valid, found;

    assign tid_f      = cur_tid;
    assign pc_f       = pc[cur_tid];
    assign pc_plus4_f = pc[cur_tid] + ADDRESS_WIDTH'(4);
    assign valid_f    = cur_valid & thread_en[cur_tid];
    assign flush_f    = redirect_e & valid_f & (redirect_tid_e == tid_f);
    assign flush_d    = redirect_e & valid_d & (redirect_tid_e == tid_d);

    // Offset NUM_THREADS wraps to zero, so cur_tid itself is considered last.
    always_comb begin
        next_tid = cur_tid;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = cur_tid + BITS_THREADS'(i);
            if (!found && thread_en[idx]) begin
                next_tid = idx;
                found    = 1'b1;
            end
        end
    end

    // Redirect is written last so it overrides the +4 on the same thread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) pc[i] <= ADDRESS_WIDTH'(RESET_PC);
            cur_tid   <= BITS_THREADS'(NUM_THREADS - 1);
            cur_valid <= 1'b0;
        end else begin
            if (!stall_f) begin
                if (valid_f) pc[cur_tid] <= pc_plus4_f;
                cur_tid   <= next_tid;
                cur_valid <= |thread_en;
            end
            if (redirect_e) pc[redirect_tid_e] <= redirect_pc_e;
        end
    end
endmodule

// File: tb/tb_barrel_sched.sv
// tb_barrel_sched: scoreboard bench for barrel_sched against a queue-fed reference model.
module tb_barrel_sched;
    localparam int AW = 32;
    localparam int NT = 8;
    localparam int BT = 3;

    typedef struct packed {
        logic [BT-1:0] tid;
        logic [AW-1:0] pc;
        logic [AW-1:0] p4;
        logic          v;
        logic          ff;
        logic          fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_f;
    logic [NT-1:0] thread_en;
    logic          redirect_e;
    logic [BT-1:0] redirect_tid_e;
    logic [AW-1:0] redirect_pc_e;
    logic [BT-1:0] tid_d;
    logic          valid_d;
    logic [BT-1:0] tid_f;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_plus4_f;
    logic          valid_f;
    logic          flush_f;
    logic          flush_d;

    barrel_sched #(.ADDRESS_WIDTH(AW), .NUM_THREADS(NT), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .thread_en(thread_en),
        .redirect_e(redirect_e), .redirect_tid_e(redirect_tid_e), .redirect_pc_e(redirect_pc_e),
        .tid_d(tid_d), .valid_d(valid_d), .tid_f(tid_f), .pc_f(pc_f),
        .pc_plus4_f(pc_plus4_f), .valid_f(valid_f), .flush_f(flush_f), .flush_d(flush_d)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int unsigned m_pc [NT];
    int          m_tid;
    bit          m_valid;

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) m_pc[i] = 0;
        m_tid   = NT - 1;
        m_valid = 0;
    endfunction

    // Inputs change just after a posedge and are held through the next one.
    task automatic apply(input bit rst, input logic [NT-1:0] en, input bit st, input bit re,
                         input int rtid, input int unsigned rpc, input int tidd, input bit vd);
        exp_t e;
        bit   v;
        @(posedge clk);
        #1;
        rst_n = rst; thread_en = en; stall_f = st; redirect_e = re;
        redirect_tid_e = BT'(rtid); redirect_pc_e = rpc; tid_d = BT'(tidd); valid_d = vd;
        if (!rst) model_reset();
        v      = m_valid && en[m_tid];
        e.tid  = BT'(m_tid);
        e.pc   = m_pc[m_tid];
        e.p4   = m_pc[m_tid] + 4;
        e.v    = v;
        e.ff   = re && v && rtid == m_tid;
        e.fd   = re && vd && rtid == tidd;
        q.push_back(e);
        if (rst) begin
            if (!st) begin
                if (v) m_pc[m_tid] = m_pc[m_tid] + 4;
                if (en != 0) begin
                    for (int k = 1; k <= NT; k++)
                        if (en[(m_tid + k) % NT]) begin
                            m_tid = (m_tid + k) % NT;
                            break;
                        end
                end
                m_valid = (en != 0);
            end
            if (re) m_pc[rtid] = rpc;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{tid_f, pc_f, pc_plus4_f, valid_f, flush_f, flush_d};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got tid=%0d pc=%h p4=%h v=%b ff=%b fd=%b, expected tid=%0d pc=%h p4=%h v=%b ff=%b fd=%b",
                         $time, a.tid, a.pc, a.p4, a.v, a.ff, a.fd, e.tid, e.pc, e.p4, e.v, e.ff, e.fd);
            end
        end
    end

    initial begin
        rst_n = 0; stall_f = 0; thread_en = '1; redirect_e = 0;
        redirect_tid_e = 0; redirect_pc_e = 0; tid_d = 0; valid_d = 0;
        model_reset();
        apply(0, 8'hFF, 0, 0, 0, 0, 0, 0);
        apply(0, 8'hFF, 0, 0, 0, 0, 0, 0);
        repeat (17) apply(1, 8'hFF, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(1, 8'hFF, 1, 0, 0, 0, 0, 0);
        apply(1, 8'hFF, 0, 1, m_tid, 32'h100, 0, 0);
        repeat (9) apply(1, 8'hFF, 0, 0, 0, 0, 0, 0);
        apply(1, 8'hFF, 1, 1, 6, 32'h200, 6, 1);
        apply(1, 8'hFF, 1, 1, 6, 32'h300, 6, 0);
        repeat (8) apply(1, 8'b0010_0101, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(1, 8'h00, 0, 0, 0, 0, 0, 0);
        repeat (6) apply(1, 8'h10, 0, 0, 0, 0, 0, 0);
        apply(0, 8'h10, 0, 0, 0, 0, 0, 0);
        repeat (4) apply(1, 8'h10, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            logic [NT-1:0] en;
            en = ($urandom_range(0, 7) == 0) ? NT'($urandom_range(0, 1) << $urandom_range(0, NT - 1))
                                             : NT'($urandom);
            apply($urandom_range(0, 79) != 0, en, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, NT - 1),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, NT - 1), $urandom_range(0, 1) == 1);
        end
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/barrel_sched.md
BARREL_SCHED -- requirements
Module: barrel_sched

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, PC width.
REQ-002 SHALL have parameter NUM_THREADS, default 8, hardware thread count (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, start PC of every thread.
REQ-004 SHALL derive localparam BITS_THREADS = $clog2(NUM_THREADS).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port stall_f, input, 1, 1 = hold scheduler state (fetch/decode stalled).
REQ-008 SHALL have port thread_en, input, NUM_THREADS, per-thread run mask.
REQ-009 SHALL have port redirect_e, input, 1, execute-stage jump or taken branch.
REQ-010 SHALL have port redirect_tid_e, input, BITS_THREADS, thread being redirected.
REQ-011 SHALL have port redirect_pc_e, input, ADDRESS_WIDTH, redirect target.
REQ-012 SHALL have port tid_d, input, BITS_THREADS, thread currently in decode.
REQ-013 SHALL have port valid_d, input, 1, decode slot holds a real instruction.
REQ-014 SHALL have port tid_f, output, BITS_THREADS, thread issued to fetch this cycle.
REQ-015 SHALL have port pc_f, output, ADDRESS_WIDTH, fetch PC of tid_f.
REQ-016 SHALL have port pc_plus4_f, output, ADDRESS_WIDTH, pc_f + 4.
REQ-017 SHALL have port valid_f, output, 1, fetch slot is a real issue.
REQ-018 SHALL have port flush_f, output, 1, kill the fetch-slot instruction.
REQ-019 SHALL have port flush_d, output, 1, clr for the decode/execute pipeline register.

Function
REQ-020 SHALL hold one ADDRESS_WIDTH PC register per thread, a cur_tid register and a cur_valid register.
REQ-021 SHALL drive tid_f = cur_tid, pc_f = pc[cur_tid], pc_plus4_f = pc[cur_tid] + 4 (mod 2^ADDRESS_WIDTH), valid_f = cur_valid & thread_en[cur_tid], all combinational from state.
REQ-022 SHALL, each edge with stall_f=0, set cur_tid to the first index with thread_en set, searching cur_tid+1, cur_tid+2, ... wrapping modulo NUM_THREADS and including cur_tid itself last.
REQ-023 SHALL, when thread_en is all zero at a non-stalled edge, clear cur_valid and hold cur_tid; otherwise set cur_valid.
REQ-024 SHALL, at a non-stalled edge with valid_f=1, update pc[cur_tid] <= pc_plus4_f.
REQ-025 SHALL, at any edge with redirect_e=1, update pc[redirect_tid_e] <= redirect_pc_e regardless of stall_f.
REQ-026 SHALL give redirect priority over the +4 increment when both target the same thread in one edge.
REQ-027 SHALL hold cur_tid, cur_valid and all non-redirected PCs while stall_f=1.
REQ-028 SHALL drive flush_f = redirect_e & valid_f & (redirect_tid_e == tid_f), combinational.
REQ-029 SHALL drive flush_d = redirect_e & valid_d & (redirect_tid_e == tid_d), combinational.
REQ-030 SHALL treat a single enabled thread as issuing every non-stalled cycle.
REQ-031 SHALL apply thread_en changes at the next selection; the thread shown in the current cycle is gated only via valid_f.

Reset
REQ-032 SHALL, while rst_n=0, set every pc[i] = RESET_PC, cur_tid = NUM_THREADS-1, cur_valid = 0, independent of clk.
REQ-033 SHALL therefore output valid_f=0, flush_f=0, tid_f=NUM_THREADS-1, pc_f=RESET_PC during reset.
REQ-034 SHALL issue the lowest enabled thread (thread 0 if enabled) at the first non-stalled edge after rst_n rises.
REQ-035 SHALL abort any in-progress rotation on mid-operation reset, with no partial PC update.

Verification
REQ-036 Reset, thread_en=8'hFF, no stall -> tid_f 0,1,..,7,0; each thread's pc_f 0 on first issue, 4 on second.
REQ-037 thread_en=8'b0010_0101 -> tid_f cycles 0,2,5,0,2,5; thread_en=0 -> valid_f=0, PCs frozen.
REQ-038 stall_f=1 for 3 cycles while tid_f=3 -> tid_f stays 3, pc[3] unchanged; resumes with tid_f=4.
REQ-039 redirect_e=1, redirect_tid_e=tid_f=2, redirect_pc_e=0x100 at an issue edge -> flush_f=1 that cycle; thread 2 next issues pc_f=0x100, not old+4.
REQ-040 redirect_e=1 with redirect_tid_e=tid_d=6, valid_d=1, stall_f=1 -> flush_d=1, pc[6]=target after edge; valid_d=0 -> flush_d=0.
REQ-041 thread_en=8'h10 only -> tid_f=4 every cycle, pc_f 0,4,8,...; rst_n pulsed low mid-run -> pc_f=0, valid_f=0 immediately.
